// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage inputs and stage-control outputs shared between the datapath and pipe_ctrl
interface pipe_ctrl_if #(
    parameter int RA_W = 5,
    parameter int CNT_W = 16
);
    logic id_valid;
    logic [5:0] id_opcode;
    logic [RA_W-1:0] id_rs, id_rt, id_rd;
    logic mem_zero;
    logic stall, flush;
    logic ex_ALUSrc;
    logic [1:0] ex_ALUOp;
    logic mem_MemRead, mem_MemWrite;
    logic wb_RegWrite, wb_MemtoReg;
    logic [RA_W-1:0] wb_dest;
    logic [1:0] fwd_a, fwd_b;
    logic illegal_op;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, mem_zero,
        input stall, flush, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
        input wb_RegWrite, wb_MemtoReg, wb_dest, fwd_a, fwd_b, illegal_op, stall_cnt, flush_cnt
    );
    modport slave (
        input id_valid, id_opcode, id_rs, id_rt, id_rd, mem_zero,
        output stall, flush, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
        output wb_RegWrite, wb_MemtoReg, wb_dest, fwd_a, fwd_b, illegal_op, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline control with decode, load-use stall, branch flush and forwarding
module pipe_ctrl #(
    parameter int RA_W = 5,
    parameter int CNT_W = 16,
    parameter bit FLUSH_EN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    pipe_ctrl_if.slave p
);
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    logic reg_dst, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, unknown, uses_rt;
    logic [1:0] alu_op;
    logic [RA_W-1:0] dest;
    logic ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic [RA_W-1:0] ex_rs, ex_rt, ex_dest;
    logic mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write, mem_branch;
    logic [RA_W-1:0] mem_dest;
    logic wb_reg_write, wb_mem_to_reg;
    logic [RA_W-1:0] wb_dest;
    logic hazard, flush, stall, bubble, illegal;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    always_comb begin
        {reg_dst, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, alu_op} =
            p.id_opcode == OP_R    ? 9'b1_1_0_0_0_0_0_10 :
            p.id_opcode == OP_LW   ? 9'b0_1_1_1_1_0_0_00 :
            p.id_opcode == OP_SW   ? 9'b0_0_1_0_0_1_0_00 :
            p.id_opcode == OP_BEQ  ? 9'b0_0_0_0_0_0_1_01 :
            p.id_opcode == OP_ADDI ? 9'b0_1_1_0_0_0_0_00 : 9'b0;
        unknown = !(p.id_opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI});
        uses_rt = p.id_opcode inside {OP_R, OP_SW, OP_BEQ};
        dest = reg_dst ? p.id_rd : p.id_rt;
        hazard = ex_mem_read && ex_rt != '0 && p.id_valid &&
                 (ex_rt == p.id_rs || (ex_rt == p.id_rt && uses_rt));
        flush = FLUSH_EN && mem_branch && p.mem_zero;
        // a taken branch kills the dependent load-use pair, so it overrides the stall
        stall = hazard && !flush;
        bubble = stall || flush || !p.id_valid;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_alu_op} <= '0;
            {ex_rs, ex_rt, ex_dest} <= '0;
            {mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write, mem_branch, mem_dest} <= '0;
            {wb_reg_write, wb_mem_to_reg, wb_dest} <= '0;
            illegal <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_alu_op,
             ex_rs, ex_rt, ex_dest} <= bubble ? '0 :
                {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, alu_op, p.id_rs, p.id_rt, dest};
            {mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write, mem_branch, mem_dest} <= flush ? '0 :
                {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_dest};
            {wb_reg_write, wb_mem_to_reg, wb_dest} <= {mem_reg_write, mem_mem_to_reg, mem_dest};
            illegal <= p.id_valid && unknown && !stall && !flush;
            stall_cnt <= stall_cnt + CNT_W'(stall && stall_cnt != '1);
            flush_cnt <= flush_cnt + CNT_W'(flush && flush_cnt != '1);
        end
    end
    assign p.stall = stall;
    assign p.flush = flush;
    assign p.ex_ALUSrc = ex_alu_src;
    assign p.ex_ALUOp = ex_alu_op;
    assign p.mem_MemRead = mem_mem_read;
    assign p.mem_MemWrite = mem_mem_write;
    assign p.wb_RegWrite = wb_reg_write;
    assign p.wb_MemtoReg = wb_mem_to_reg;
    assign p.wb_dest = wb_dest;
    assign p.fwd_a = mem_reg_write && mem_dest != '0 && mem_dest == ex_rs ? 2'b10 :
                     wb_reg_write && wb_dest != '0 && wb_dest == ex_rs ? 2'b01 : 2'b00;
    assign p.fwd_b = mem_reg_write && mem_dest != '0 && mem_dest == ex_rt ? 2'b10 :
                     wb_reg_write && wb_dest != '0 && wb_dest == ex_rt ? 2'b01 : 2'b00;
    assign p.illegal_op = illegal;
    assign p.stall_cnt = stall_cnt;
    assign p.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus queues per-cycle expectations; a negedge monitor checks them
module tb_pipe_ctrl;
    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, ADDI = 6'h08, BAD = 6'h3f;
    typedef enum int {F_STALL, F_FLUSH, F_EXSRC, F_EXOP, F_MRD, F_MWR, F_RW, F_M2R, F_WBDEST,
                      F_FA, F_FB, F_ILL, F_SCNT, F_FCNT, F_FLUSH_NF, F_SCNT2} fld_t;
    typedef struct {int cyc; fld_t f; int val; string name;} exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    int cyc = 0, n_tests = 0, n_fail = 0;
    exp_t sb[$];
    pipe_ctrl_if #(.RA_W(5), .CNT_W(16)) i ();
    pipe_ctrl_if #(.RA_W(5), .CNT_W(16)) i_nf ();
    pipe_ctrl_if #(.RA_W(5), .CNT_W(2)) i_c2 ();
    pipe_ctrl #(.RA_W(5), .CNT_W(16), .FLUSH_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .p(i));
    pipe_ctrl #(.RA_W(5), .CNT_W(16), .FLUSH_EN(1'b0)) dut_nf (.clk(clk), .rst_n(rst_n), .p(i_nf));
    pipe_ctrl #(.RA_W(5), .CNT_W(2), .FLUSH_EN(1'b1)) dut_c2 (.clk(clk), .rst_n(rst_n), .p(i_c2));
    assign {i_nf.id_valid, i_nf.id_opcode, i_nf.id_rs, i_nf.id_rt, i_nf.id_rd, i_nf.mem_zero} =
           {i.id_valid, i.id_opcode, i.id_rs, i.id_rt, i.id_rd, i.mem_zero};
    assign {i_c2.id_valid, i_c2.id_opcode, i_c2.id_rs, i_c2.id_rt, i_c2.id_rd, i_c2.mem_zero} =
           {i.id_valid, i.id_opcode, i.id_rs, i.id_rt, i.id_rd, i.mem_zero};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int get(fld_t f);
        case (f)
            F_STALL: return int'(i.stall);
            F_FLUSH: return int'(i.flush);
            F_EXSRC: return int'(i.ex_ALUSrc);
            F_EXOP: return int'(i.ex_ALUOp);
            F_MRD: return int'(i.mem_MemRead);
            F_MWR: return int'(i.mem_MemWrite);
            F_RW: return int'(i.wb_RegWrite);
            F_M2R: return int'(i.wb_MemtoReg);
            F_WBDEST: return int'(i.wb_dest);
            F_FA: return int'(i.fwd_a);
            F_FB: return int'(i.fwd_b);
            F_ILL: return int'(i.illegal_op);
            F_SCNT: return int'(i.stall_cnt);
            F_FCNT: return int'(i.flush_cnt);
            F_FLUSH_NF: return int'(i_nf.flush);
            default: return int'(i_c2.stall_cnt);
        endcase
    endfunction
    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].cyc <= cyc) begin
                n_tests++;
                if (sb[k].cyc != cyc || get(sb[k].f) != sb[k].val) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[k].name, get(sb[k].f), sb[k].val, cyc);
                end
                sb.delete(k);
            end
    end
    task automatic exp(int off, fld_t f, int val, string name);
        sb.push_back('{cyc + off, f, val, name});
    endtask
    task automatic tick(logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic mz = 1'b0);
        @(posedge clk);
        #1;
        {i.id_valid, i.id_opcode, i.id_rs, i.id_rt, i.id_rd, i.mem_zero} = {v, op, rs, rt, rd, mz};
    endtask
    task automatic nop(int n);
        repeat (n) tick(1'b0, R, 5'd0, 5'd0, 5'd0);
    endtask
    task automatic exp_all_zero(string name);
        for (int f = F_STALL; f <= F_SCNT2; f++) exp(0, fld_t'(f), 0, name);
    endtask
    initial begin
        {i.id_valid, i.id_opcode, i.id_rs, i.id_rt, i.id_rd, i.mem_zero} = '0;
        tick(1, LW, 1, 2, 0);
        exp_all_zero("reset_state");
        nop(1);
        rst_n = 1'b1;
        nop(1);
        // load-use: lw r2 then add r3,r2,r4
        tick(1, LW, 1, 2, 0);
        exp(0, F_STALL, 0, "lw_nostall"); exp(1, F_EXSRC, 1, "lw_ex_alusrc"); exp(1, F_EXOP, 0, "lw_ex_aluop");
        tick(1, R, 2, 4, 3);
        exp(0, F_STALL, 1, "lu_stall"); exp(1, F_STALL, 0, "lu_stall_1cyc"); exp(1, F_SCNT, 1, "lu_scnt");
        exp(1, F_MRD, 1, "lw_mem_rd"); exp(1, F_EXSRC, 0, "lu_bubble"); exp(2, F_FA, 1, "lu_fwd_a");
        exp(2, F_FB, 0, "lu_fwd_b"); exp(2, F_EXOP, 2, "add_ex_aluop"); exp(2, F_M2R, 1, "lw_wb_m2r");
        exp(2, F_RW, 1, "lw_wb_rw"); exp(2, F_WBDEST, 2, "lw_wb_dest");
        tick(1, R, 2, 4, 3);
        nop(3);
        // forwarding
        tick(1, R, 1, 2, 5); tick(1, R, 5, 5, 6);
        exp(1, F_FA, 2, "fwd_mem_a"); exp(1, F_FB, 2, "fwd_mem_b");
        nop(3);
        tick(1, R, 1, 2, 5); nop(1); tick(1, R, 5, 5, 6);
        exp(1, F_FA, 1, "fwd_wb_a"); exp(1, F_FB, 1, "fwd_wb_b");
        nop(3);
        tick(1, R, 1, 2, 0); tick(1, R, 0, 0, 6);
        exp(1, F_FA, 0, "fwd_r0_a"); exp(1, F_FB, 0, "fwd_r0_b");
        nop(3);
        tick(1, R, 1, 2, 5); tick(1, ADDI, 1, 5, 0); tick(1, R, 5, 5, 6);
        exp(1, F_FA, 2, "fwd_pri_a"); exp(1, F_FB, 2, "fwd_pri_b");
        nop(3);
        tick(1, R, 1, 2, 5); tick(1, R, 3, 5, 6);
        exp(1, F_FA, 0, "fwd_only_b_a"); exp(1, F_FB, 2, "fwd_only_b_b");
        nop(3);
        // decode of sw, invalid slot, non-stalling hazards
        tick(1, SW, 1, 2, 0);
        exp(1, F_EXSRC, 1, "sw_ex_alusrc"); exp(2, F_MWR, 1, "sw_mem_wr"); exp(2, F_MRD, 0, "sw_mem_rd");
        exp(3, F_RW, 0, "sw_wb_rw");
        nop(3);
        tick(0, LW, 1, 2, 0);
        exp(1, F_EXSRC, 0, "invalid_ex"); exp(2, F_MRD, 0, "invalid_mem");
        nop(3);
        tick(1, LW, 1, 2, 0); tick(1, ADDI, 3, 2, 0);
        exp(0, F_STALL, 0, "addi_rt_nostall");
        nop(3);
        tick(1, LW, 1, 0, 0); tick(1, R, 0, 0, 3);
        exp(0, F_STALL, 0, "lw_r0_nostall");
        nop(3);
        // branch flush
        tick(1, BEQ, 1, 2, 0);
        exp(1, F_EXOP, 1, "beq_ex_aluop"); exp(2, F_FLUSH, 0, "br_not_taken");
        nop(3);
        tick(1, BEQ, 1, 2, 0); tick(1, SW, 3, 4, 0); tick(1, LW, 3, 7, 0, 1'b1);
        exp(0, F_FLUSH, 1, "br_flush"); exp(0, F_FLUSH_NF, 0, "br_flush_disabled"); exp(0, F_STALL, 0, "br_nostall");
        exp(1, F_FLUSH, 0, "br_flush_1cyc"); exp(1, F_EXSRC, 0, "br_ex_bubble"); exp(1, F_MWR, 0, "br_mem_bubble");
        exp(1, F_FCNT, 1, "br_fcnt");
        nop(3);
        // load-use meeting a taken branch
        tick(1, BEQ, 1, 2, 0); tick(1, LW, 1, 2, 0); tick(1, R, 2, 4, 3, 1'b1);
        exp(0, F_STALL, 0, "fl_st_stall"); exp(0, F_FLUSH, 1, "fl_st_flush"); exp(1, F_SCNT, 1, "fl_st_scnt");
        exp(1, F_FCNT, 2, "fl_st_fcnt"); exp(1, F_MRD, 0, "fl_st_mem_bubble"); exp(1, F_SCNT2, 1, "fl_st_scnt2");
        nop(3);
        // illegal opcode
        tick(1, BAD, 1, 2, 3);
        exp(0, F_ILL, 0, "ill_not_yet"); exp(1, F_ILL, 1, "ill_pulse"); exp(1, F_EXSRC, 0, "ill_ex_src");
        exp(1, F_EXOP, 0, "ill_ex_op"); exp(2, F_ILL, 0, "ill_one_cyc"); exp(2, F_MRD, 0, "ill_mem_rd");
        exp(3, F_RW, 0, "ill_wb_rw");
        tick(0, BAD, 1, 2, 3);
        exp(1, F_ILL, 0, "ill_invalid");
        nop(3);
        // four more load-use stalls: narrow counter saturates at 3
        for (int k = 1; k <= 4; k++) begin
            tick(1, LW, 1, 2, 0); tick(1, R, 2, 4, 3);
            exp(0, F_STALL, 1, "sat_stall");
            tick(1, R, 2, 4, 3);
            exp(0, F_SCNT, 1 + k, "sat_scnt"); exp(0, F_SCNT2, k + 1 > 3 ? 3 : k + 1, "sat_scnt2");
            nop(3);
        end
        // reset mid-stall, between edges
        tick(1, LW, 1, 2, 0); tick(1, R, 2, 4, 3);
        #1 rst_n = 1'b0;
        exp_all_zero("async_reset");
        #1;
        n_tests++;
        if (i.stall !== 1'b0) begin n_fail++; $display("FAIL rst_direct_stall: got %0d", i.stall); end
        n_tests++;
        if (i.mem_MemRead !== 1'b0) begin n_fail++; $display("FAIL rst_direct_mrd: got %0d", i.mem_MemRead); end
        n_tests++;
        if (i.ex_ALUSrc !== 1'b0) begin n_fail++; $display("FAIL rst_direct_exsrc: got %0d", i.ex_ALUSrc); end
        n_tests++;
        if (i.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_direct_scnt: got %0d", i.stall_cnt); end
        tick(1, LW, 1, 2, 0);
        exp(0, F_SCNT, 0, "in_reset_scnt"); exp(0, F_EXSRC, 0, "in_reset_ex");
        tick(1, ADDI, 1, 9, 0);
        rst_n = 1'b1;
        exp(0, F_EXSRC, 0, "rel_wait_edge"); exp(1, F_EXSRC, 1, "rel_addi_src"); exp(1, F_EXOP, 0, "rel_addi_op");
        exp(1, F_STALL, 0, "rel_stall"); exp(3, F_RW, 1, "rel_wb_rw"); exp(3, F_WBDEST, 9, "rel_wb_dest");
        exp(3, F_M2R, 0, "rel_wb_m2r");
        nop(4);
        repeat (2) @(negedge clk);
        #1;
        foreach (sb[k]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never compared, expected %0d at cycle %0d", sb[k].name, sb[k].val, sb[k].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter RA_W, default 5, which sets the register address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, which sets the width of the stall and flush event counters.
REQ-003 The block SHALL have parameter FLUSH_EN, default 1, which enables the branch flush (1) or disables it (0).
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 id_valid  in  1  the ID stage holds a real instruction.
REQ-007 id_opcode  in  6  opcode of the instruction in ID.
REQ-008 id_rs, id_rt, id_rd  in  RA_W each  register fields of the instruction in ID.
REQ-009 mem_zero  in  1  ALU zero flag of the instruction in MEM.
REQ-010 stall  out  1  hold PC and IF/ID (combinational).
REQ-011 flush  out  1  clear IF/ID (combinational).
REQ-012 ex_ALUSrc  out  1  ID/EX control bit; ex_ALUOp  out  2  ID/EX control field.
REQ-013 mem_MemRead, mem_MemWrite  out  1 each  EX/MEM control bits.
REQ-014 wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB control bits; wb_dest  out  RA_W  MEM/WB destination register.
REQ-015 fwd_a, fwd_b  out  2 each  forwarding mux selects (combinational).
REQ-016 illegal_op  out  1  registered, one-cycle pulse.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  event counters.

Function
REQ-018 The decode SHALL produce the following {RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, ALUOp}, with no X values:
- R-type 000000 -> 1,1,0,0,0,0,0,10
- lw 100011 -> 0,1,1,1,1,0,0,00
- sw 101011 -> 0,0,1,0,0,1,0,00
- beq 000100 -> 0,0,0,0,0,0,1,01
- addi 001000 -> 0,1,1,0,0,0,0,00
- any other opcode -> all zero
REQ-019 The block SHALL compute the destination register as dest = RegDst ? id_rd : id_rt.
REQ-020 Each cycle, ID/EX SHALL latch the decoded bundle together with id_rs, id_rt and dest; it SHALL latch an all-zero bubble instead when stall, flush or !id_valid is asserted.
REQ-021 EX/MEM and MEM/WB SHALL shift forward every cycle; when flush is asserted, EX/MEM SHALL latch a bubble.
REQ-022 Control latency SHALL be: a non-stalled ID instruction's bits appear on ex_* after 1 cycle, on mem_* after 2 cycles, and on wb_* after 3 cycles.
REQ-023 stall SHALL equal all of the following: ex_MemRead, ex_rt != 0, id_valid, and either ex_rt == id_rs, or (ex_rt == id_rt and the ID opcode is R-type, sw or beq).
REQ-024 For a single load-use pair, stall SHALL last exactly 1 cycle, because the inserted bubble clears ex_MemRead.
REQ-025 The block SHALL compute branch_taken = mem_Branch & mem_zero.
REQ-026 flush SHALL equal branch_taken & FLUSH_EN.
REQ-027 When flush and stall coincide, flush SHALL win: stall is forced to 0 and a bubble enters ID/EX.
REQ-028 fwd_a SHALL be:
- 10 when mem_RegWrite, mem_dest != 0 and mem_dest == ex_rs;
- otherwise 01 when wb_RegWrite, wb_dest != 0 and wb_dest == ex_rs;
- otherwise 00.
REQ-029 fwd_b SHALL follow the REQ-028 rules with ex_rt in place of ex_rs; the MEM-stage match SHALL take priority over the WB-stage match.
REQ-030 illegal_op SHALL pulse for 1 cycle, in the cycle after the one in which id_valid & unknown opcode & !stall & !flush held.
REQ-031 stall_cnt SHALL increment on each stall cycle and flush_cnt on each flush cycle; both SHALL saturate at 2^CNT_W-1 with no wrap-around.

Reset
REQ-032 When rst_n = 0, all pipeline registers, counters and illegal_op SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-033 While in reset, every registered output SHALL read 0.
REQ-034 stall, flush, fwd_a and fwd_b SHALL read 0 during reset, because the stage registers are 0.
REQ-035 Deassertion of rst_n SHALL take effect at the next rising edge of clk.
REQ-036 Asserting reset in the middle of a stall or flush SHALL abort it; no residual bubble or count SHALL remain.

Verification
REQ-037 lw r2 followed by add r3,r2,r4 -> stall=1 for exactly one cycle, the add reaches EX one cycle later, fwd_a=01 at that point, and stall_cnt=1.
REQ-038 beq with mem_zero=1 in MEM and FLUSH_EN=1 -> flush=1 for one cycle, the next ex_* and mem_* read as bubbles, and flush_cnt=1; with FLUSH_EN=0 -> flush stays 0.
REQ-039 add r5 followed immediately by sub r6,r5,r5 -> fwd_a=fwd_b=10; with add r5, nop, sub -> fwd_a=fwd_b=01; with destination r0 -> 00.
REQ-040 Load-use stall coinciding with a branch flush -> stall=0, flush=1, and stall_cnt is unchanged.
REQ-041 Opcode 111111 with id_valid=1 -> one illegal_op pulse and all control bits 0; with CNT_W=2 and 5 stalls -> stall_cnt=3.
REQ-042 rst_n driven low mid-stream, between clock edges -> all outputs read 0 before the next edge, and the first instruction after release decodes correctly.
